// File: rtl/gemm_pkg.sv
// Shared constants and FSM state encoding for the GEMM tile array.
// Default parameter values live here so the top and the bench agree on them.
package gemm_pkg;

   localparam int unsigned DefInDataWidth   = 8;
   localparam int unsigned DefOutDataWidth  = 32;
   localparam int unsigned DefAddrWidth     = 16;
   localparam int unsigned DefSizeAddrWidth = 8;
   localparam int unsigned DefRowPar        = 4;
   localparam int unsigned DefColPar        = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/gemm_tile_pe.sv
// Single signed multiply-accumulate cell; clear has priority over accumulate.
// The product is sign-extended to the accumulator width and the sum wraps.
module gemm_tile_pe #(
   parameter int unsigned InDataWidth  = 8,
   parameter int unsigned OutDataWidth = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clr_i,
   input  logic                           en_i,
   input  logic signed [InDataWidth-1:0]  a_i,
   input  logic signed [InDataWidth-1:0]  b_i,
   output logic signed [OutDataWidth-1:0] acc_o
);

   logic signed [2*InDataWidth-1:0] prod;
   logic signed [OutDataWidth-1:0]  prod_ext;

   assign prod     = a_i * b_i;
   assign prod_ext = OutDataWidth'(prod);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_o <= '0;
      end else if (clr_i) begin
         acc_o <= '0;
      end else if (en_i) begin
         acc_o <= acc_o + prod_ext;
      end
   end

endmodule

// File: rtl/gemm_tile_array.sv
// Tiled C = A x B engine: RowPar x ColPar MAC grid, one k step per cycle, one-cycle SRAM reads.
// Each tile costs K+2 cycles (RUN, DRAIN, WRITE); edge lanes outside M/N are masked off.
module gemm_tile_array
   import gemm_pkg::*;
#(
   parameter int unsigned InDataWidth   = DefInDataWidth,
   parameter int unsigned OutDataWidth  = DefOutDataWidth,
   parameter int unsigned AddrWidth     = DefAddrWidth,
   parameter int unsigned SizeAddrWidth = DefSizeAddrWidth,
   parameter int unsigned RowPar        = DefRowPar,
   parameter int unsigned ColPar        = DefColPar
) (
   input  logic                                            clk_i,
   input  logic                                            rst_ni,
   input  logic                                            start_i,
   input  logic [SizeAddrWidth-1:0]                        M_size_i,
   input  logic [SizeAddrWidth-1:0]                        K_size_i,
   input  logic [SizeAddrWidth-1:0]                        N_size_i,
   output logic [RowPar-1:0][AddrWidth-1:0]                sram_a_addr_o,
   input  logic [RowPar-1:0][InDataWidth-1:0]              sram_a_rdata_i,
   output logic [ColPar-1:0][AddrWidth-1:0]                sram_b_addr_o,
   input  logic [ColPar-1:0][InDataWidth-1:0]              sram_b_rdata_i,
   output logic [RowPar-1:0][ColPar-1:0][AddrWidth-1:0]    sram_c_addr_o,
   output logic [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0] sram_c_wdata_o,
   output logic [RowPar-1:0][ColPar-1:0]                   sram_c_we_o,
   output logic                                            busy_o,
   output logic                                            done_o
);

   localparam int unsigned IdxW = SizeAddrWidth + 1;

   state_e                   state_q;
   logic [SizeAddrWidth-1:0] m_q, k_q, n_q;
   logic [SizeAddrWidth-1:0] row_base_q, col_base_q, k_cnt_q;
   logic                     rd_vld_q;

   logic                     st_run, st_write, pe_clr;
   logic [IdxW-1:0]          next_row, next_col;
   logic [RowPar-1:0][IdxW-1:0] row_idx;
   logic [ColPar-1:0][IdxW-1:0] col_idx;
   logic [RowPar-1:0]        row_vld;
   logic [ColPar-1:0]        col_vld;

   assign st_run   = (state_q == RUN);
   assign st_write = (state_q == WRITE);
   // Clearing on k==0 is safe: no read data is in flight on a tile's first RUN cycle.
   assign pe_clr   = st_run && (k_cnt_q == '0);
   assign next_row = {1'b0, row_base_q} + IdxW'(RowPar);
   assign next_col = {1'b0, col_base_q} + IdxW'(ColPar);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         m_q        <= '0;
         k_q        <= '0;
         n_q        <= '0;
         row_base_q <= '0;
         col_base_q <= '0;
         k_cnt_q    <= '0;
         rd_vld_q   <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         done_o   <= 1'b0;
         rd_vld_q <= st_run;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  m_q        <= M_size_i;
                  k_q        <= K_size_i;
                  n_q        <= N_size_i;
                  row_base_q <= '0;
                  col_base_q <= '0;
                  k_cnt_q    <= '0;
                  busy_o     <= 1'b1;
                  if ((M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0)) begin
                     state_q <= DONE;
                     done_o  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (k_cnt_q == k_q - SizeAddrWidth'(1)) begin
                  k_cnt_q <= '0;
                  state_q <= DRAIN;
               end else begin
                  k_cnt_q <= k_cnt_q + SizeAddrWidth'(1);
               end
            end
            DRAIN: state_q <= WRITE;
            WRITE: begin
               if (next_col < {1'b0, n_q}) begin
                  col_base_q <= next_col[SizeAddrWidth-1:0];
                  state_q    <= RUN;
               end else if (next_row < {1'b0, m_q}) begin
                  row_base_q <= next_row[SizeAddrWidth-1:0];
                  col_base_q <= '0;
                  state_q    <= RUN;
               end else begin
                  state_q <= DONE;
                  done_o  <= 1'b1;
               end
            end
            DONE: begin
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar r = 0; r < RowPar; r++) begin : g_row_addr
      assign row_idx[r]       = {1'b0, row_base_q} + IdxW'(r);
      assign row_vld[r]       = row_idx[r] < {1'b0, m_q};
      assign sram_a_addr_o[r] = (st_run && row_vld[r])
                              ? AddrWidth'(row_idx[r]) * AddrWidth'(k_q) + AddrWidth'(k_cnt_q)
                              : '0;
   end

   for (genvar c = 0; c < ColPar; c++) begin : g_col_addr
      assign col_idx[c]       = {1'b0, col_base_q} + IdxW'(c);
      assign col_vld[c]       = col_idx[c] < {1'b0, n_q};
      assign sram_b_addr_o[c] = (st_run && col_vld[c])
                              ? AddrWidth'(k_cnt_q) * AddrWidth'(n_q) + AddrWidth'(col_idx[c])
                              : '0;
   end

   for (genvar r = 0; r < RowPar; r++) begin : g_pe_row
      for (genvar c = 0; c < ColPar; c++) begin : g_pe_col
         logic                           lane_we;
         logic signed [OutDataWidth-1:0] acc;

         gemm_tile_pe #(
            .InDataWidth (InDataWidth),
            .OutDataWidth(OutDataWidth)
         ) u_pe (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .clr_i (pe_clr),
            .en_i  (rd_vld_q),
            .a_i   (sram_a_rdata_i[r]),
            .b_i   (sram_b_rdata_i[c]),
            .acc_o (acc)
         );

         assign lane_we              = st_write && row_vld[r] && col_vld[c];
         assign sram_c_we_o[r][c]    = lane_we;
         assign sram_c_addr_o[r][c]  = lane_we
                                     ? AddrWidth'(row_idx[r]) * AddrWidth'(n_q) + AddrWidth'(col_idx[c])
                                     : '0;
         assign sram_c_wdata_o[r][c] = lane_we ? acc : '0;
      end
   end

endmodule

// File: tb/tb_gemm_tile_array.sv
// Directed bench for gemm_tile_array: behavioural A/B SRAMs, C write scoreboard,
// hand-computed spot values plus a reference matrix product.
module tb_gemm_tile_array;

   logic                     clk_i = 1'b0;
   logic                     rst_ni;
   logic                     start_i;
   logic [7:0]               M_size_i, K_size_i, N_size_i;
   logic [3:0][15:0]         sram_a_addr_o;
   logic [3:0][7:0]          sram_a_rdata_i;
   logic [3:0][15:0]         sram_b_addr_o;
   logic [3:0][7:0]          sram_b_rdata_i;
   logic [3:0][3:0][15:0]    sram_c_addr_o;
   logic [3:0][3:0][31:0]    sram_c_wdata_o;
   logic [3:0][3:0]          sram_c_we_o;
   logic                     busy_o, done_o;

   logic signed [7:0]  mem_a [256];
   logic signed [7:0]  mem_b [256];
   logic signed [31:0] c_mem [256];
   int                 c_hits [256];
   int                 wr_cnt;
   int                 oob_cnt;
   int                 n_vec = 0;
   int                 n_err = 0;

   gemm_tile_array dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .M_size_i      (M_size_i),
      .K_size_i      (K_size_i),
      .N_size_i      (N_size_i),
      .sram_a_addr_o (sram_a_addr_o),
      .sram_a_rdata_i(sram_a_rdata_i),
      .sram_b_addr_o (sram_b_addr_o),
      .sram_b_rdata_i(sram_b_rdata_i),
      .sram_c_addr_o (sram_c_addr_o),
      .sram_c_wdata_o(sram_c_wdata_o),
      .sram_c_we_o   (sram_c_we_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      for (int r = 0; r < 4; r++) sram_a_rdata_i[r] <= mem_a[sram_a_addr_o[r][7:0]];
      for (int c = 0; c < 4; c++) sram_b_rdata_i[c] <= mem_b[sram_b_addr_o[c][7:0]];
   end

   always @(negedge clk_i) begin
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (sram_c_we_o[r][c]) begin
               wr_cnt++;
               if (sram_c_addr_o[r][c] < 16'd256) begin
                  c_mem[sram_c_addr_o[r][c][7:0]]  = sram_c_wdata_o[r][c];
                  c_hits[sram_c_addr_o[r][c][7:0]] = c_hits[sram_c_addr_o[r][c][7:0]] + 1;
               end else begin
                  oob_cnt++;
               end
            end
         end
      end
   end

   function automatic int golden(input int i, input int j, input int k, input int n);
      int s = 0;
      for (int kk = 0; kk < k; kk++) s += int'(mem_a[i*k+kk]) * int'(mem_b[kk*n+j]);
      return s;
   endfunction

   task automatic scb_clear();
      wr_cnt  = 0;
      oob_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         c_mem[i]  = 32'hDEAD_BEEF;
         c_hits[i] = 0;
      end
   endtask

   // Called #1 after a rising edge; returns the cycle index of done_o (0 on timeout).
   task automatic run_op(input int m, input int k, input int n, input bit repulse,
                         input int budget, output int done_cyc, output int busy_cyc);
      int cyc;
      done_cyc = 0;
      busy_cyc = 0;
      start_i  = 1'b1;
      M_size_i = 8'(m);
      K_size_i = 8'(k);
      N_size_i = 8'(n);
      @(posedge clk_i);
      #1;
      start_i  = 1'b0;
      M_size_i = 8'hFF;
      K_size_i = 8'hFF;
      N_size_i = 8'hFF;
      cyc = 1;
      while (cyc <= budget) begin
         if (busy_o) busy_cyc++;
         if (done_o && done_cyc == 0) done_cyc = cyc;
         start_i = (repulse && cyc == 2);
         if (done_cyc != 0 && cyc >= done_cyc + 2) break;
         @(posedge clk_i);
         #1;
         cyc++;
      end
      start_i = 1'b0;
   endtask

   task automatic load_seq_4x3x4();
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < 12; i++) begin
         mem_a[i] = 8'(i + 1);
         mem_b[i] = 8'(i + 1);
      end
   endtask

   task automatic test_reset();
      rst_ni   = 1'b0;
      start_i  = 1'b0;
      M_size_i = '0;
      K_size_i = '0;
      N_size_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      n_vec++;
      if ({busy_o, done_o} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_flags busy/done=%b expected 00", {busy_o, done_o});
      end
      n_vec++;
      if (sram_c_we_o !== '0 || sram_c_addr_o !== '0 || sram_c_wdata_o !== '0) begin
         n_err++;
         $display("FAIL reset_c_port we=%h addr=%h expected all zero", sram_c_we_o, sram_c_addr_o);
      end
      n_vec++;
      if (sram_a_addr_o !== '0 || sram_b_addr_o !== '0) begin
         n_err++;
         $display("FAIL reset_ab_addr a=%h b=%h expected 0", sram_a_addr_o, sram_b_addr_o);
      end
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_single_tile(input bit repulse);
      int dc, bc, bad;
      load_seq_4x3x4();
      scb_clear();
      run_op(4, 3, 4, repulse, 40, dc, bc);
      n_vec++;
      if (dc !== 6) begin
         n_err++;
         $display("FAIL single_done_cycle got %0d expected 6 (repulse=%0d)", dc, repulse);
      end
      n_vec++;
      if (bc !== 6) begin
         n_err++;
         $display("FAIL single_busy_cycles got %0d expected 6", bc);
      end
      n_vec++;
      if (wr_cnt !== 16) begin
         n_err++;
         $display("FAIL single_write_count got %0d expected 16", wr_cnt);
      end
      n_vec++;
      if (c_mem[0] !== 32'sd38 || c_mem[15] !== 32'sd272) begin
         n_err++;
         $display("FAIL single_corners c00=%0d c33=%0d expected 38 272", c_mem[0], c_mem[15]);
      end
      bad = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (c_mem[i*4+j] !== golden(i, j, 3, 4)) bad++;
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL single_matrix %0d elements differ from reference product, expected 0", bad);
      end
   endtask

   task automatic test_edge_tiles();
      int dc, bc, bad, hit_bad;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 2; j++) mem_a[i*2+j] = 8'(i*2 + j + 1);
      for (int k = 0; k < 2; k++)
         for (int n = 0; n < 6; n++) mem_b[k*6+n] = 8'(k*6 + n + 1);
      scb_clear();
      run_op(5, 2, 6, 1'b0, 60, dc, bc);
      n_vec++;
      if (dc !== 17) begin
         n_err++;
         $display("FAIL edge_done_cycle got %0d expected 17", dc);
      end
      n_vec++;
      if (wr_cnt !== 30) begin
         n_err++;
         $display("FAIL edge_write_count got %0d expected 30", wr_cnt);
      end
      hit_bad = oob_cnt;
      for (int i = 0; i < 256; i++) hit_bad += (c_hits[i] != ((i < 30) ? 1 : 0)) ? 1 : 0;
      n_vec++;
      if (hit_bad !== 0) begin
         n_err++;
         $display("FAIL edge_masking %0d addresses written wrongly, expected 0", hit_bad);
      end
      n_vec++;
      if (c_mem[29] !== 32'sd174) begin
         n_err++;
         $display("FAIL edge_last_elem got %0d expected 174", c_mem[29]);
      end
      bad = 0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 6; j++)
            if (c_mem[i*6+j] !== golden(i, j, 2, 6)) bad++;
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL edge_matrix %0d elements differ from reference product, expected 0", bad);
      end
   endtask

   task automatic test_zero_size();
      int dc, bc;
      scb_clear();
      run_op(4, 0, 4, 1'b0, 20, dc, bc);
      n_vec++;
      if (dc !== 1 || bc !== 1) begin
         n_err++;
         $display("FAIL zero_k done_cycle=%0d busy_cycles=%0d expected 1 1", dc, bc);
      end
      run_op(0, 3, 4, 1'b0, 20, dc, bc);
      n_vec++;
      if (dc !== 1) begin
         n_err++;
         $display("FAIL zero_m done_cycle got %0d expected 1", dc);
      end
      n_vec++;
      if (wr_cnt !== 0) begin
         n_err++;
         $display("FAIL zero_writes got %0d expected 0", wr_cnt);
      end
   endtask

   task automatic test_extremes();
      int dc, bc;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = 8'h80;
         mem_b[i] = 8'h80;
      end
      scb_clear();
      run_op(4, 8, 4, 1'b0, 40, dc, bc);
      n_vec++;
      if (dc !== 11) begin
         n_err++;
         $display("FAIL extreme_done_cycle got %0d expected 11", dc);
      end
      n_vec++;
      if (c_mem[0] !== 32'sd131072 || c_mem[15] !== 32'sd131072) begin
         n_err++;
         $display("FAIL extreme_neg_neg c00=%0d c33=%0d expected 131072", c_mem[0], c_mem[15]);
      end
      for (int i = 0; i < 32; i++) mem_b[i] = 8'h7F;
      scb_clear();
      run_op(4, 8, 4, 1'b0, 40, dc, bc);
      n_vec++;
      if (c_mem[5] !== -32'sd130048 || c_mem[10] !== -32'sd130048) begin
         n_err++;
         $display("FAIL extreme_neg_pos c11=%0d c22=%0d expected -130048", c_mem[5], c_mem[10]);
      end
   endtask

   task automatic test_abort();
      int dc, bc;
      load_seq_4x3x4();
      scb_clear();
      start_i  = 1'b1;
      M_size_i = 8'd4;
      K_size_i = 8'd3;
      N_size_i = 8'd4;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      n_vec++;
      if ({busy_o, done_o} !== 2'b00 || sram_c_we_o !== '0 || sram_a_addr_o !== '0) begin
         n_err++;
         $display("FAIL abort_outputs busy/done=%b we=%h a_addr=%h expected all zero",
                  {busy_o, done_o}, sram_c_we_o, sram_a_addr_o);
      end
      rst_ni = 1'b1;
      repeat (10) @(posedge clk_i);
      #1;
      n_vec++;
      if (wr_cnt !== 0) begin
         n_err++;
         $display("FAIL abort_writes got %0d expected 0", wr_cnt);
      end
      test_single_tile(1'b0);
   endtask

   initial begin
      test_reset();
      test_single_tile(1'b0);
      test_edge_tiles();
      test_zero_size();
      test_extremes();
      test_single_tile(1'b1);
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gemm_tile_array.md
GEMM_TILE_ARRAY -- requirements
Module: gemm_tile_array

Interface
REQ-001 SHALL have parameter InDataWidth, default 8, signed A/B element width.
REQ-002 SHALL have parameter OutDataWidth, default 32, signed accumulator/C element width.
REQ-003 SHALL have parameter AddrWidth, default 16, SRAM address width.
REQ-004 SHALL have parameter SizeAddrWidth, default 8, M/K/N size width.
REQ-005 SHALL have parameter RowPar, default 4, PE rows per tile.
REQ-006 SHALL have parameter ColPar, default 4, PE columns per tile.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset; one clock, reset synchronous and active-low.
REQ-008 SHALL have ports: start_i in 1 start pulse; M_size_i, K_size_i, N_size_i in SizeAddrWidth each, unsigned sizes.
REQ-009 SHALL have ports: sram_a_addr_o out RowPar x AddrWidth; sram_a_rdata_i in RowPar x InDataWidth signed.
REQ-010 SHALL have ports: sram_b_addr_o out ColPar x AddrWidth; sram_b_rdata_i in ColPar x InDataWidth signed.
REQ-011 SHALL have ports: sram_c_addr_o out RowPar x ColPar x AddrWidth; sram_c_wdata_o out RowPar x ColPar x OutDataWidth signed; sram_c_we_o out RowPar x ColPar.
REQ-012 SHALL have ports: busy_o out 1 operation in progress; done_o out 1 single-cycle completion pulse.

Function
REQ-013 SHALL latch M/K/N sizes on start_i in IDLE; later size changes ignored until next start.
REQ-014 SHALL ignore start_i when not in IDLE.
REQ-015 SHALL implement FSM IDLE -> RUN -> DRAIN -> WRITE -> (RUN next tile | DONE) -> IDLE; DONE lasts one cycle.
REQ-016 SHALL go IDLE -> DONE directly when any latched size is zero; no C writes.
REQ-017 SHALL tile M in steps of RowPar (outer loop), N in steps of ColPar (inner loop); tile counts ceil(M/RowPar), ceil(N/ColPar).
REQ-018 SHALL, in RUN, step k 0..K-1 one per cycle, driving sram_a_addr_o[r]=(row_base+r)*K+k and sram_b_addr_o[c]=k*N+col_base+c (row-major A and B), truncated to AddrWidth.
REQ-019 SHALL treat SRAM read latency as exactly one cycle; PE(r,c) accumulates a[r]*b[c] on the cycle after address issue.
REQ-020 SHALL use DRAIN (one cycle) to accumulate the k=K-1 data.
REQ-021 SHALL, in WRITE, assert sram_c_we_o[r][c] only for valid lanes (row_base+r<M and col_base+c<N), with sram_c_addr_o[r][c]=(row_base+r)*N+col_base+c and sram_c_wdata_o[r][c]=accumulator.
REQ-022 SHALL drive address 0 and we 0 on invalid (edge) lanes; invalid-lane accumulators are don't-care.
REQ-023 SHALL clear all accumulators on the first RUN cycle of each tile, without losing that tile's first product.
REQ-024 SHALL sign-extend the product to OutDataWidth; accumulation wraps modulo 2^OutDataWidth.
REQ-025 SHALL hold busy_o high from the cycle after accepted start through DONE inclusive; done_o high only in DONE.
REQ-026 SHALL give latency per tile K+2 cycles; total tiles*(K+2)+1 cycles from start to done_o.
REQ-027 SHALL keep sram_c_we_o all-zero outside WRITE.

Reset
REQ-028 SHALL on rst_ni low at clock edge enter IDLE; busy_o, done_o, sram_c_we_o, all addresses, wdata, accumulators and counters 0.
REQ-029 SHALL abort mid-operation on reset with no further C writes; next start behaves as fresh.

Structure
REQ-030 SHALL place the FSM state enum and default parameter constants in shared package gemm_pkg.
REQ-031 SHALL use one sub-module gemm_tile_pe (single signed MAC with clear/enable), instantiated RowPar x ColPar by generate loops.
REQ-032 SHALL keep tile/k counters and address generation in the top module.

Verification
REQ-033 M=4,K=3,N=4, A=1..12, B=1..12 -> one tile, 16 writes matching golden, done_o at cycle 6 after start.
REQ-034 M=5,K=2,N=6 (Row/ColPar 4) -> 4 tiles, exactly 30 writes, no write to masked lanes, done_o at cycle 17.
REQ-035 K=0 -> done_o one cycle after start, zero writes, busy_o one cycle.
REQ-036 A=-128, B=-128, K=8 -> C=131072 per element; B=127,A=-128 -> C=-130048.
REQ-037 start_i re-pulsed mid-run and rst_ni low mid-run -> re-pulse ignored; reset stops writes, all outputs 0, subsequent run correct.
